// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - RAM-to-stream reader with 2-entry output FIFO; optional MEM_STREAM_READER_STRIDE_EN adds a stride input
module mem_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
`ifdef MEM_STREAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_wr_busy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fifo_count;

  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_occupancy;
  logic                  w_mem_re;
  logic [ADDR_WIDTH-1:0] w_step;

`ifdef MEM_STREAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] r_stride;
  assign w_step = r_stride;
`else
  assign w_step = ADDR_WIDTH'(1);
`endif

  // A word leaves when the head is valid and downstream accepts it; the
  // word read last cycle always lands in the FIFO this cycle.
  assign w_pop  = (r_fifo_count != 2'd0) && out_ready;
  assign w_push = r_inflight;

  // Occupancy the FIFO will have once this cycle's push/pop settle; a new
  // read is only safe if its data will still find a free slot next cycle.
  assign w_occupancy = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  // Read issue is combinational so a write-port collision holds the read
  // back in the very cycle it occurs; the address is simply retried.
  assign w_mem_re = !rst && (r_state == S_RUN) && (r_remaining != '0) &&
                    !mem_wr_busy && (w_occupancy < 3'd2);

  assign mem_re    = w_mem_re;
  assign mem_raddr = r_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = (r_fifo_count != 2'd0);
  assign out_data  = r_fifo[r_rd_ptr];

  // Command FSM: address/count bookkeeping, busy and done generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef MEM_STREAM_READER_STRIDE_EN
      r_stride    <= '0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_mem_re;
      if (w_mem_re) begin
        r_addr      <= r_addr + w_step;
        r_remaining <= r_remaining - {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= len;
            r_busy      <= 1'b1;
`ifdef MEM_STREAM_READER_STRIDE_EN
            r_stride    <= stride;
`endif
            r_state     <= (len == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_mem_re && (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1})) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // busy stays high through the done cycle and drops in IDLE.
          if (!r_inflight && (r_fifo_count == 2'd0)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Two-entry output FIFO fed by the one-cycle-late RAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_fifo_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_rdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb/tb_mem_stream_reader.sv - directed bench for mem_stream_reader
module tb_mem_stream_reader;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wr_busy;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ram [256];

  logic [DW-1:0] got [$];
  logic [AW-1:0] raddr_q [$];
  int re_cnt, bad_re, done_cnt, stall_err, n_stall, ovf;
  int cyc = 0, last_xfer_cyc, done_cyc;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .mem_re      (mem_re),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_wr_busy (mem_wr_busy),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // RAM read port: suppressed reads return a poison value.
  always @(posedge clk) begin
    if (mem_re && !mem_wr_busy) mem_rdata <= ram[mem_raddr];
    else                        mem_rdata <= 32'hDEADBEEF;
    cyc <= cyc + 1;
  end

  // Monitor on the falling edge, where all inputs and outputs are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_xfer_cyc = cyc;
      end
      if (mem_re) begin
        re_cnt++;
        raddr_q.push_back(mem_raddr);
      end
      if (mem_re && mem_wr_busy) bad_re++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dut.r_fifo_count > 2'd2) ovf++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      if (out_valid && !out_ready) n_stall++;
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    raddr_q.delete();
    re_cnt = 0; bad_re = 0; done_cnt = 0; stall_err = 0; n_stall = 0; ovf = 0;
    last_xfer_cyc = 0; done_cyc = 0;
  endtask

  task automatic wait_done(input int max_cyc, input bit bp, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (bp) out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      step();
      if (done) seen = 1'b1;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int first, input int n);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) check({tag, "_data"}, got[i], first + i);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = i + 100;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    mem_wr_busy = 1'b0; out_ready = 1'b1;
    step(); step();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    step();

    // Basic: base 4, len 8, free-running sink
    clear_mon();
    base_addr = 8'd4; len = 9'd8; start = 1'b1;
    step();
    start = 1'b0; #1;
    check("basic_busy", busy, 1);
    check("basic_re_first", mem_re, 1);
    check("basic_raddr_first", mem_raddr, 4);
    check("basic_valid_e0", out_valid, 0);
    step(); #1;
    check("basic_valid_e1", out_valid, 0);
    step(); #1;
    check("basic_valid_e2", out_valid, 1);
    check("basic_data_e2", out_data, 104);
    wait_done(40, 1'b0, "basic");
    check("basic_busy_at_done", busy, 1);
    step(); #1;
    check("basic_busy_after", busy, 0);
    check("basic_done_pulse", done, 0);
    check_seq("basic", 104, 8);
    check("basic_re_cycles", re_cnt, 8);
    check("basic_done_lag", done_cyc - last_xfer_cyc, 2);

    // Address wrap: 254,255,0,1
    clear_mon();
    base_addr = 8'd254; len = 9'd4; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, 1'b0, "wrap");
    step();
    check("wrap_re_count", raddr_q.size(), 4);
    if (raddr_q.size() == 4) begin
      check("wrap_addr0", raddr_q[0], 254);
      check("wrap_addr1", raddr_q[1], 255);
      check("wrap_addr2", raddr_q[2], 0);
      check("wrap_addr3", raddr_q[3], 1);
    end
    check("wrap_out_count", got.size(), 4);
    if (got.size() == 4) begin
      check("wrap_out0", got[0], 354);
      check("wrap_out1", got[1], 355);
      check("wrap_out2", got[2], 100);
      check("wrap_out3", got[3], 101);
    end

    // Backpressure: ready pattern 1,0,0,1
    clear_mon();
    base_addr = 8'd10; len = 9'd6; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(80, 1'b1, "bp");
    step();
    check_seq("bp", 110, 6);
    check("bp_stable", stall_err, 0);
    check("bp_no_overflow", ovf, 0);
    check("bp_stalled", 32'(n_stall > 0), 1);

    // Write contention on RUN cycles 2 and 3
    clear_mon();
    base_addr = 8'd20; len = 9'd4; start = 1'b1;
    step();
    start = 1'b0; #1;
    check("wr_re_c1", mem_re, 1);
    check("wr_raddr_c1", mem_raddr, 20);
    step();
    mem_wr_busy = 1'b1; #1;
    check("wr_re_c2", mem_re, 0);
    check("wr_raddr_c2", mem_raddr, 21);
    step(); #1;
    check("wr_re_c3", mem_re, 0);
    step();
    mem_wr_busy = 1'b0; #1;
    check("wr_re_c4", mem_re, 1);
    check("wr_raddr_c4", mem_raddr, 21);
    wait_done(40, 1'b0, "wr");
    step();
    check_seq("wr", 120, 4);
    check("wr_re_cycles", re_cnt, 4);
    check("wr_re_collide", bad_re, 0);

    // len = 0
    clear_mon();
    base_addr = 8'd7; len = 9'd0; start = 1'b1;
    step();
    start = 1'b0; #1;
    check("len0_busy", busy, 1);
    check("len0_re", mem_re, 0);
    check("len0_done_early", done, 0);
    step(); #1;
    check("len0_done", done, 1);
    step(); #1;
    check("len0_done_end", done, 0);
    check("len0_busy_end", busy, 0);
    check("len0_re_cycles", re_cnt, 0);
    check("len0_outputs", got.size(), 0);
    check("len0_done_count", done_cnt, 1);

    // start while busy is ignored
    clear_mon();
    base_addr = 8'd30; len = 9'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    base_addr = 8'd50; len = 9'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, 1'b0, "ign");
    step(); step(); step();
    check_seq("ign", 130, 4);
    check("ign_re_cycles", re_cnt, 4);
    check("ign_done_count", done_cnt, 1);

    // Reset at third output, with start held alongside reset
    clear_mon();
    base_addr = 8'd40; len = 9'd8; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step(); #1;
    check("rmid_third", out_data, 142);
    rst = 1'b1; start = 1'b1;
    step(); #1;
    check("rmid_busy", busy, 0);
    check("rmid_done", done, 0);
    check("rmid_re", mem_re, 0);
    check("rmid_raddr", mem_raddr, 0);
    check("rmid_valid", out_valid, 0);
    check("rmid_data", out_data, 0);
    rst = 1'b0; start = 1'b0;
    step(); step(); #1;
    check("rmid_no_done", done_cnt, 0);
    check("rmid_idle", busy, 0);
    clear_mon();
    base_addr = 8'd0; len = 9'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, 1'b0, "rnew");
    step();
    check_seq("rnew", 100, 3);
    check("rnew_done_count", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
